// File: rtl/servo_cmd_scheduler.sv
// Servo command scheduler: two one-deep command slots with round-robin grant,
// go/complete handshake with the UART sender, post-command gap and timeout.
`timescale 1ns/1ps
module servo_cmd_scheduler #(
    parameter int GAP_CYCLES     = 2500000,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch0_valid,
    input  logic [23:0] ch0_cmd,
    input  logic        ch1_valid,
    input  logic [23:0] ch1_cmd,
    output logic [11:0] sc_angle,
    output logic [3:0]  sc_id,
    output logic [3:0]  sc_seconds,
    output logic [3:0]  sc_hundreds_ms,
    output logic        sc_go,
    input  logic        sc_complete,
    output logic [1:0]  pending,
    output logic [1:0]  overwrite,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_GAP
    } state_t;

    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
    localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 2) ? TIMEOUT_CYCLES - 2 : 0;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_LAST_I);

    state_t           state_q, state_d;
    logic [1:0][23:0] slot_q, slot_d;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       ovw_q, ovw_d;
    logic             last_q, last_d;
    logic [23:0]      sc_q, sc_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             err_q, err_d;

    logic [1:0]       valid;
    logic [1:0][23:0] cmd;
    logic             grant;
    logic             gch;
    logic [1:0]       gnt_vec;

    assign valid = {ch1_valid, ch0_valid};
    assign cmd   = {ch1_cmd, ch0_cmd};

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        pend_d  = pend_q;
        ovw_d   = '0;
        last_d  = last_q;
        sc_d    = sc_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        grant   = 1'b0;
        // On a tie the channel that was not granted last wins
        gch     = (pend_q == 2'b11) ? ~last_q : pend_q[1];

        unique case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    grant   = 1'b1;
                    sc_d    = slot_q[gch];
                    last_d  = gch;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW, S_WAIT_HIGH: begin
                // Limit counts the go cycle too, so the flag rises
                // exactly TIMEOUT_CYCLES cycles after sc_go
                if (tmo_q >= TO_LAST) begin
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (state_q == S_WAIT_LOW && !sc_complete) begin
                        state_d = S_WAIT_HIGH;
                    end else if (state_q == S_WAIT_HIGH && sc_complete) begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q >= GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        gnt_vec = {grant & gch, grant & ~gch};
        for (int n = 0; n < 2; n++) begin
            if (valid[n]) begin
                slot_d[n] = cmd[n];
                pend_d[n] = 1'b1;
                ovw_d[n]  = pend_q[n] & ~gnt_vec[n];
            end else if (gnt_vec[n]) begin
                pend_d[n] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            pend_q  <= '0;
            ovw_q   <= '0;
            last_q  <= 1'b1;
            sc_q    <= '0;
            gap_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            pend_q  <= pend_d;
            ovw_q   <= ovw_d;
            last_q  <= last_d;
            sc_q    <= sc_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign sc_id          = sc_q[23:20];
    assign sc_seconds     = sc_q[19:16];
    assign sc_hundreds_ms = sc_q[15:12];
    assign sc_angle       = sc_q[11:0];
    assign sc_go          = (state_q == S_ISSUE);
    assign busy           = (state_q != S_IDLE);
    assign pending        = pend_q;
    assign overwrite      = ovw_q;
    assign timeout_err    = err_q;

endmodule

// File: doc/servo_cmd_scheduler.md
SERVO_CMD_SCHEDULER -- requirements
Module: servo_cmd_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 2500000: idle cycles enforced after each command (50 ms at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 5000000: maximum cycles allowed from sc_go to the completion handshake.
REQ-003 clk  input  1  clock, 50 MHz.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 ch0_valid  input  1  one-cycle strobe; latches ch0_cmd.
REQ-006 ch0_cmd  input  24  {id[23:20], seconds[19:16], hundreds_ms[15:12], angle[11:0]}.
REQ-007 ch1_valid  input  1  one-cycle strobe; latches ch1_cmd.
REQ-008 ch1_cmd  input  24  same packing as ch0_cmd.
REQ-009 sc_angle  output  12  angle sent to the servo UART sender.
REQ-010 sc_id  output  4  servo ID.
REQ-011 sc_seconds  output  4  move seconds.
REQ-012 sc_hundreds_ms  output  4  move time, hundreds-of-ms digit.
REQ-013 sc_go  output  1  one-cycle start pulse.
REQ-014 sc_complete  input  1  sender done flag; high when idle, low while sending.
REQ-015 pending  output  2  bit N set while a channel-N command waits.
REQ-016 overwrite  output  2  one-cycle pulse when a pending channel-N command is replaced before issue.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 timeout_err  output  1  sticky error flag; cleared only by reset.

Function
REQ-019 Each channel SHALL have a one-deep slot; chN_valid loads chN_cmd and sets pending[N] on the next edge.
REQ-020 chN_valid while pending[N]=1 and the slot is not being granted SHALL overwrite the slot and pulse overwrite[N] for one cycle.
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT_LOW, WAIT_HIGH and GAP.
REQ-022 IDLE with any pending bit set SHALL grant one channel: copy its slot to sc_* registers, clear its pending bit, and enter ISSUE.
REQ-023 Arbitration SHALL be round-robin.
  - If both channels are pending, the channel not granted last wins.
  - The last-grant pointer resets to ch1, so ch0 wins the first tie.
REQ-024 If chN_valid arrives in the same cycle that channel N is granted:
  - the old slot content is issued;
  - the new command is stored and pending[N] stays 1;
  - no overwrite pulse is generated.
REQ-025 sc_go SHALL be high only in ISSUE, for exactly one cycle; ISSUE always goes to WAIT_LOW.
REQ-026 sc_* outputs SHALL hold their values from grant until the next grant.
REQ-027 WAIT_LOW SHALL wait for sc_complete=0, then enter WAIT_HIGH.
REQ-028 WAIT_HIGH SHALL wait for sc_complete=1, then enter GAP.
REQ-029 A timeout counter SHALL clear in ISSUE and increment in WAIT_LOW and WAIT_HIGH.
  - When it reaches TIMEOUT_CYCLES: set timeout_err and enter GAP.
REQ-030 GAP SHALL count GAP_CYCLES cycles, then enter IDLE.
  - With GAP_CYCLES=0, GAP lasts exactly one cycle.
REQ-031 Command latency SHALL be fixed.
  - chN_valid in cycle t with the FSM idle and nothing else pending gives sc_go high in cycle t+2.
REQ-032 Counters SHALL be wide enough for the parameter values and SHALL saturate, never wrap.

Reset
REQ-033 Reset SHALL act immediately in any state, including mid-command, and set:
  - state to IDLE;
  - sc_go, busy, pending, overwrite, timeout_err and counters to 0;
  - sc_* data to 0;
  - last-grant pointer to ch1.
REQ-034 The first grant after reset SHALL not depend on the level of sc_complete.

Verification (GAP_CYCLES=4, TIMEOUT_CYCLES=64; sender model drops complete 2 cycles after go and raises it 20 cycles later)
REQ-035 Single command: ch0_valid with cmd 0x312_5DC -> sc_go at t+2; sc_id=3, sc_seconds=1, sc_hundreds_ms=2, sc_angle=0x5DC; busy falls 5 cycles after complete rises.
REQ-036 Tie: ch0_valid and ch1_valid in the same cycle -> ch0 issued first, then ch1; a second simultaneous pair -> ch0 then ch1 again (alternating).
REQ-037 Overwrite: ch1 is pending while ch0 is in flight; a second ch1_valid with angle 0x7D0 -> overwrite[1] pulses once; only angle 0x7D0 is issued.
REQ-038 Timeout: sender model never drops complete -> timeout_err=1 at go+64 cycles; the next pending command is still issued after GAP.
REQ-039 Reset mid-WAIT_HIGH with ch1 pending -> all outputs 0 next cycle; a new ch1_valid issues normally at t+2.
REQ-040 Same-cycle valid and grant on ch0 -> old command issued, pending[0]=1, overwrite[0]=0.
